// File: rtl/spi_byte_slave.sv
// SPI mode-0 slave front end, oversampled by clk: byte deserialiser on MOSI, reply serialiser on MISO.
// Optional feature macro SPI_FRAME_ERR_EN adds the frame_err pulse for truncated frames.
module spi_byte_slave #(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] rx_byte,
  output logic       cycle_done,
  input  logic [7:0] tx_byte,
  output logic       busy
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s, cs_n_s, mosi_s;
  logic                   sclk_rise, sclk_fall;
  state_t                 state, next_state;
  logic                   in_frame;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift, tx_shift, rx_next;

  function automatic logic first_bit(input logic [7:0] b);
    return MSB_FIRST ? b[7] : b[0];
  endfunction

  function automatic logic tx_bit(input logic [7:0] s, input logic [2:0] n);
    return MSB_FIRST ? s[3'd7 - n] : s[n];
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] s, input logic b);
    return MSB_FIRST ? {s[6:0], b} : {b, s[7:1]};
  endfunction

  // Input synchronisers; idle levels on reset so no spurious edge follows release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_n_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign rx_next   = shift_in(rx_shift, mosi_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Edges count only while the frame is open and CS is still low, so a CS
  // release landing on the same clk as an SCLK edge always wins.
  always_comb begin
    next_state = state;
    in_frame   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_n_s) next_state = ACTIVE;
      end
      ACTIVE: begin
        busy     = 1'b1;
        in_frame = !cs_n_s;
        if (cs_n_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      tx_shift   <= 8'h00;
      rx_byte    <= 8'h00;
      cycle_done <= 1'b0;
      spi_miso   <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (!in_frame) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
        spi_miso <= first_bit(tx_byte);
      end else if (sclk_rise) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd0) tx_shift <= tx_byte;
        if (bit_cnt == 3'd7) begin
          rx_byte    <= rx_next;
          cycle_done <= 1'b1;
        end
      end else if (sclk_fall) begin
        spi_miso <= (bit_cnt != 3'd0) ? tx_bit(tx_shift, bit_cnt) : first_bit(tx_byte);
      end else if (bit_cnt == 3'd0) begin
        // Between bytes the first reply bit follows tx_byte so late updates still land.
        spi_miso <= first_bit(tx_byte);
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= (state == ACTIVE) && cs_n_s && (bit_cnt != 3'd0);
  end
`endif

endmodule

// File: tb/tb_spi_byte_slave.sv
// Directed bench for spi_byte_slave: three instances (default, LSB-first, SYNC_STAGES=3)
// share the SPI master lines; each task checks its own scenario.
module tb_spi_byte_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_byte = 8'h00;

  logic       miso_m, miso_l, miso_s;
  logic [7:0] rx_m, rx_l, rx_s;
  logic       cd_m, cd_l, cd_s;
  logic       busy_m, busy_l, busy_s;
`ifdef SPI_FRAME_ERR_EN
  logic       fe_m, fe_l, fe_s;
`endif

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int cnt_m = 0, cnt_l = 0, cnt_s = 0, cnt_fe = 0, wide_m = 0;
  int lat_s = 0;
  int last_rise_cyc = 0;
  logic cd_m_prev = 1'b0;
  logic [7:0] upd_q[$];
  int upd_sel = 0;

  spi_byte_slave dut (
    .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso_m), .rx_byte(rx_m), .cycle_done(cd_m), .tx_byte(tx_byte), .busy(busy_m)
`ifdef SPI_FRAME_ERR_EN
    , .frame_err(fe_m)
`endif
  );

  spi_byte_slave #(.SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso_l), .rx_byte(rx_l), .cycle_done(cd_l), .tx_byte(tx_byte), .busy(busy_l)
`ifdef SPI_FRAME_ERR_EN
    , .frame_err(fe_l)
`endif
  );

  spi_byte_slave #(.SYNC_STAGES(3), .MSB_FIRST(1'b1)) dut_s3 (
    .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso_s), .rx_byte(rx_s), .cycle_done(cd_s), .tx_byte(tx_byte), .busy(busy_s)
`ifdef SPI_FRAME_ERR_EN
    , .frame_err(fe_s)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors, sampled on the inactive edge.
  always @(negedge clk) begin
    cd_m_prev <= cd_m;
    if (cd_m) cnt_m <= cnt_m + 1;
    if (cd_m && cd_m_prev) wide_m <= wide_m + 1;
    if (cd_l) cnt_l <= cnt_l + 1;
    if (cd_s) begin
      cnt_s <= cnt_s + 1;
      lat_s <= cyc - last_rise_cyc;
    end
`ifdef SPI_FRAME_ERR_EN
    if (fe_m) cnt_fe <= cnt_fe + 1;
`endif
  end

  // Consumer model: loads the next reply byte two clocks after a cycle_done.
  initial begin
    forever begin
      @(negedge clk);
      if ((upd_sel == 1 && cd_m) || (upd_sel == 3 && cd_s)) begin
        repeat (2) @(negedge clk);
        if (upd_q.size() > 0) tx_byte = upd_q.pop_front();
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Master: nbits of mode-0 transfer at sclk = clk/8; sel picks which slave's miso is sampled.
  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit msb,
                          input int sel, output logic [7:0] got);
    int idx;
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? 7 - i : i;
      mosi = b[idx];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      last_rise_cyc = cyc;
      case (sel)
        1:       got[idx] = miso_m;
        2:       got[idx] = miso_l;
        default: got[idx] = miso_s;
      endcase
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    #1;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (miso_m !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso_m); end
    vectors++; if (rx_m !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h expected 00", rx_m); end
    vectors++; if (cd_m !== 1'b0) begin errors++; $display("FAIL reset_cd: got %b expected 0", cd_m); end
    vectors++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_m); end
`ifdef SPI_FRAME_ERR_EN
    vectors++; if (fe_m !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", fe_m); end
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] got;
    int c0;
    c0 = cnt_m;
    tx_byte = 8'h3C;
    cs_low();
    vectors++; if (busy_m !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy_m); end
    spi_bits(8'hA5, 8, 1'b1, 1, got);
    cs_high();
    vectors++; if (rx_m !== 8'hA5) begin errors++; $display("FAIL single_rx: got %h expected a5", rx_m); end
    vectors++; if (cnt_m - c0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", cnt_m - c0); end
    vectors++; if (got !== 8'h3C) begin errors++; $display("FAIL single_miso: got %h expected 3c", got); end
    vectors++; if (busy_m !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy_m); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    int c0;
    tx_byte = 8'hFF;
    cs_low();
    spi_bits(8'hFF, 3, 1'b1, 1, got);
    c0 = cnt_m;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (miso_m !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b expected 0", miso_m); end
    vectors++; if (rx_m !== 8'h00) begin errors++; $display("FAIL rstmid_rx: got %h expected 00", rx_m); end
    vectors++; if (busy_m !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_m); end
    vectors++; if (cd_m !== 1'b0) begin errors++; $display("FAIL rstmid_cd: got %b expected 0", cd_m); end
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (cnt_m !== c0) begin errors++; $display("FAIL rstmid_nopulse: got %0d expected %0d", cnt_m, c0); end
    tx_byte = 8'h96;
    cs_low();
    spi_bits(8'hC3, 8, 1'b1, 1, got);
    cs_high();
    vectors++; if (rx_m !== 8'hC3) begin errors++; $display("FAIL rstmid_after_rx: got %h expected c3", rx_m); end
    vectors++; if (got !== 8'h96) begin errors++; $display("FAIL rstmid_after_miso: got %h expected 96", got); end
    vectors++; if (cnt_m - c0 !== 1) begin errors++; $display("FAIL rstmid_after_pulses: got %0d expected 1", cnt_m - c0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got0, got1, got2;
    int c0;
    c0 = cnt_m;
    tx_byte = 8'h3C;
    upd_q = '{8'h81, 8'h82};
    upd_sel = 1;
    cs_low();
    spi_bits(8'h11, 8, 1'b1, 1, got0);
    vectors++; if (rx_m !== 8'h11) begin errors++; $display("FAIL burst_rx0: got %h expected 11", rx_m); end
    spi_bits(8'h22, 8, 1'b1, 1, got1);
    vectors++; if (rx_m !== 8'h22) begin errors++; $display("FAIL burst_rx1: got %h expected 22", rx_m); end
    spi_bits(8'h33, 8, 1'b1, 1, got2);
    vectors++; if (rx_m !== 8'h33) begin errors++; $display("FAIL burst_rx2: got %h expected 33", rx_m); end
    cs_high();
    upd_sel = 0;
    vectors++; if (got0 !== 8'h3C) begin errors++; $display("FAIL burst_miso0: got %h expected 3c", got0); end
    vectors++; if (got1 !== 8'h81) begin errors++; $display("FAIL burst_miso1: got %h expected 81", got1); end
    vectors++; if (got2 !== 8'h82) begin errors++; $display("FAIL burst_miso2: got %h expected 82", got2); end
    vectors++; if (cnt_m - c0 !== 3) begin errors++; $display("FAIL burst_pulses: got %0d expected 3", cnt_m - c0); end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    int c0, f0;
    c0 = cnt_m;
    f0 = cnt_fe;
    tx_byte = 8'hE7;
    cs_low();
    spi_bits(8'hFF, 5, 1'b1, 1, got);
    cs_high();
    vectors++; if (rx_m !== 8'h33) begin errors++; $display("FAIL abort_rx_held: got %h expected 33", rx_m); end
    vectors++; if (busy_m !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy_m); end
`ifdef SPI_FRAME_ERR_EN
    vectors++; if (cnt_fe - f0 !== 1) begin errors++; $display("FAIL abort_frame_err: got %0d expected 1", cnt_fe - f0); end
`endif
    cs_low();
    spi_bits(8'h5A, 8, 1'b1, 1, got);
    cs_high();
    vectors++; if (rx_m !== 8'h5A) begin errors++; $display("FAIL abort_rx: got %h expected 5a", rx_m); end
    vectors++; if (cnt_m - c0 !== 1) begin errors++; $display("FAIL abort_pulses: got %0d expected 1", cnt_m - c0); end
    vectors++; if (got !== 8'hE7) begin errors++; $display("FAIL abort_miso: got %h expected e7", got); end
`ifdef SPI_FRAME_ERR_EN
    vectors++; if (cnt_fe - f0 !== 1) begin errors++; $display("FAIL abort_frame_err_total: got %0d expected 1", cnt_fe - f0); end
`endif
  endtask

  task automatic test_lsb_first();
    logic [7:0] got;
    int c0;
    c0 = cnt_l;
    tx_byte = 8'h80;
    cs_low();
    spi_bits(8'h01, 8, 1'b0, 2, got);
    cs_high();
    vectors++; if (rx_l !== 8'h01) begin errors++; $display("FAIL lsb_rx: got %h expected 01", rx_l); end
    vectors++; if (got !== 8'h80) begin errors++; $display("FAIL lsb_miso: got %h expected 80", got); end
    vectors++; if (cnt_l - c0 !== 1) begin errors++; $display("FAIL lsb_pulses: got %0d expected 1", cnt_l - c0); end
  endtask

  task automatic test_random_sync3();
    logic [7:0] sent[256];
    logic [7:0] reply[256];
    logic [7:0] got;
    int c0;
    for (int k = 0; k < 256; k++) begin
      sent[k]  = 8'($urandom_range(255));
      reply[k] = 8'($urandom_range(255));
    end
    upd_q.delete();
    for (int k = 1; k < 256; k++) upd_q.push_back(reply[k]);
    tx_byte = reply[0];
    upd_sel = 3;
    c0 = cnt_s;
    cs_low();
    for (int k = 0; k < 256; k++) begin
      spi_bits(sent[k], 8, 1'b1, 3, got);
      vectors++; if (rx_s !== sent[k]) begin errors++; $display("FAIL rand_rx[%0d]: got %h expected %h", k, rx_s, sent[k]); end
      vectors++; if (got !== reply[k]) begin errors++; $display("FAIL rand_miso[%0d]: got %h expected %h", k, got, reply[k]); end
      vectors++; if (lat_s !== 4) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 4", k, lat_s); end
    end
    cs_high();
    upd_sel = 0;
    vectors++; if (cnt_s - c0 !== 256) begin errors++; $display("FAIL rand_pulses: got %0d expected 256", cnt_s - c0); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_reset_mid();
    test_back_to_back();
    test_abort();
    test_lsb_first();
    test_random_sync3();
    vectors++; if (wide_m !== 0) begin errors++; $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_m); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
